shift_sequencer: RTL and testbench

//  Multi-cycle controller that drives the single-step shifter (one op per cycle: 00 pass, 01 LSL1, 10 LSR1, 11 ASR1).

---
 rtl/shift_pkg.sv | 19 +
 rtl/shifter.sv | 26 ++
 rtl/shift_sequencer.sv | 88 ++++++++
 tb/tb_shift_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: shifter op codes, controller states, default width.
package shift_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shifter.sv
// Single-step combinational shifter: pass, logical left/right or arithmetic right by one bit.
module shifter
    import shift_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] in,
    input  shift_op_t    shift,
    output logic [W-1:0] sout
);

    logic signed [W-1:0] in_s;

    assign in_s = $signed(in);

    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[W-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[W-1:1]};
            SH_ASR:  sout = in_s >>> 1;
            default: sout = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: accepts {value, op, amt}, steps the one-bit shifter amt times,
// and returns the result over a valid/ready response channel.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int AMT_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_value,
    input  logic [1:0]       req_op,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_value,
    output logic             busy
);

    seq_state_t       state, state_nx;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_shifted;
    logic [AMT_W-1:0] cnt;
    shift_op_t        op_q;
    logic             accept;
    logic             step;

    shifter #(.W(W)) u_shifter (
        .in    (acc),
        .shift (op_q),
        .sout  (acc_shifted)
    );

    // Both handshakes are masked while flush is high so neither side sees a transfer that gets dropped.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    accept   = 1'b1;
                    state_nx = (req_amt == '0 || req_op == SH_NONE) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = !flush;
                if (cnt == AMT_W'(1)) state_nx = DONE;
            end
            DONE: begin
                resp_valid = !flush;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= SH_NONE;
        end else begin
            state <= state_nx;
            if (accept) begin
                acc  <= req_value;
                op_q <= shift_op_t'(req_op);
                cnt  <= req_amt;
            end else if (step) begin
                acc <= acc_shifted;
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign resp_value = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed vector table, multi-cycle corner sequences, random requests vs. model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_value;
    logic [1:0]  req_op;
    logic [3:0]  req_amt;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_value;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    shift_sequencer #(.W(16), .AMT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_value  (req_value),
        .req_op     (req_op),
        .req_amt    (req_amt),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_value (resp_value),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp_val;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Whole-amount arithmetic shift, not a step-by-step replay.
    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] op, input int amt);
        logic signed [15:0] vs;
        vs = $signed(v);
        case (op)
            2'b01:   return v << amt;
            2'b10:   return v >> amt;
            2'b11:   return vs >>> amt;
            default: return v;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input int amt);
        return (op == 2'b00 || amt == 0) ? 1 : amt + 1;
    endfunction

    // Issue one request, measure latency/busy, optionally backpressure, then consume the response.
    task automatic do_req(input string tag, input logic [15:0] v, input logic [1:0] op,
                          input logic [3:0] amt, input int hold, input bit poke_req,
                          input logic [15:0] exp_val, input int exp_lat, input int exp_busy);
        int  lat;
        int  bcnt;
        bit  got;
        @(negedge clk);
        req_valid = 1'b1;
        req_value = v;
        req_op    = op;
        req_amt   = amt;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check({tag, " accept timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_value = 16'($urandom);
        req_op    = 2'($urandom);
        req_amt   = 4'($urandom);
        lat  = 1;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            check({tag, " resp timeout"}, 0, 1);
            return;
        end
        check({tag, " value"}, resp_value, exp_val);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy cycles"}, bcnt, exp_busy);
        if (poke_req) begin
            req_valid = 1'b1;
            req_value = 16'h1234;
            req_op    = 2'b01;
            req_amt   = 4'd2;
        end
        for (int h = 0; h < hold; h++) begin
            if (poke_req) check({tag, " req_ready while held"}, req_ready, 0);
            @(negedge clk);
            check({tag, " held valid"}, resp_valid, 1);
            check({tag, " held value"}, resp_value, exp_val);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic start_long(input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_value = 16'hFFFF;
        req_op    = 2'b01;
        req_amt   = 4'd8;
        check({tag, " ready before"}, req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, " busy mid-shift"}, busy, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " resp_valid"}, resp_valid, 0);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " busy"}, busy, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_value  = '0;
        req_op     = '0;
        req_amt    = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;

        vecs[0] = '{16'hF0CF, 2'b01, 4'd1,  16'hE19E, 2,  1};
        vecs[1] = '{16'hF0CF, 2'b10, 4'd4,  16'h0F0C, 5,  4};
        vecs[2] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 16, 15};
        vecs[3] = '{16'h7FFF, 2'b11, 4'd1,  16'h3FFF, 2,  1};
        vecs[4] = '{16'h9249, 2'b01, 4'd0,  16'h9249, 1,  0};
        vecs[5] = '{16'hA5C3, 2'b00, 4'd7,  16'hA5C3, 1,  0};

        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_value", resp_value, 0);
        check("reset busy", busy, 0);
        reset_n = 1'b1;

        foreach (vecs[i])
            do_req($sformatf("vec%0d", i), vecs[i].value, vecs[i].op, vecs[i].amt, 0, 1'b0,
                   vecs[i].exp_val, vecs[i].exp_lat, vecs[i].exp_busy);

        do_req("backpressure", 16'h00F3, 2'b01, 4'd2, 3, 1'b1, 16'h03CC, 3, 2);
        @(negedge clk);
        check_idle("after backpressure");

        start_long("flush");
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_idle("after flush");
        do_req("post-flush", 16'h0001, 2'b01, 4'd3, 0, 1'b0, 16'h0008, 4, 3);

        start_long("reset");
        reset_n = 1'b0;
        #1;
        check_idle("during reset");
        check("reset mid resp_value", resp_value, 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_req("post-reset", 16'h0001, 2'b01, 4'd3, 0, 1'b0, 16'h0008, 4, 3);

        // flush while a result is held in DONE drops it
        @(negedge clk);
        req_valid = 1'b1;
        req_value = 16'h0F00;
        req_op    = 2'b10;
        req_amt   = 4'd1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("done held valid", resp_valid, 1);
        flush = 1'b1;
        #1;
        check("flush masks resp_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_idle("after done flush");

        // flush beats a simultaneous request in IDLE
        req_valid = 1'b1;
        req_value = 16'h0003;
        req_op    = 2'b01;
        req_amt   = 4'd5;
        flush     = 1'b1;
        #1;
        check("flush masks req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check_idle("request under flush dropped");

        for (int k = 0; k < 200; k++) begin
            logic [15:0] v;
            logic [1:0]  op;
            logic [3:0]  amt;
            int          lat;
            v   = 16'($urandom);
            op  = 2'($urandom);
            amt = 4'($urandom);
            lat = model_lat(op, int'(amt));
            do_req($sformatf("rand%0d", k), v, op, amt, $urandom_range(0, 2), 1'b0,
                   model(v, op, int'(amt)), lat, lat - 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
